// File: rtl/button_conditioner.sv
// Pushbutton front end: two-flop synchroniser, bounce-rejecting FSM, registered
// level plus one-cycle press/release/long-press strobes and a wrapping press count.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  logic          sync1_q, sync2_q;
  state_t        state_q, state_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic [7:0]    cnt_q, cnt_d;

  // Next-state and next-output computation for the debounce FSM and hold timer
  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    cnt_d       = cnt_q;

    // The hold timer keeps running through a release glitch (ARM_RELEASE).
    if ((state_q == PRESSED) || (state_q == ARM_RELEASE)) begin
      if (!long_done_q && (hold_q == HOLD_LAST)) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else if (!long_done_q) begin
        hold_d = hold_q + HW'(1);
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d = ARM_PRESS;
          deb_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ARM_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d     = PRESSED;
          level_d     = 1'b1;
          press_d     = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!sync2_q) begin
          state_d = ARM_RELEASE;
          deb_d   = '0;
        end else begin
          state_d = PRESSED;
        end
      end
      ARM_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (deb_q == DEB_LAST) begin
          // An accepted release overrides a long threshold landing on the same edge.
          state_d     = IDLE;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_d      = 1'b0;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  // State, synchroniser and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      cnt_q       <= cnt_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_cnt     = cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses (kind, edge, count) are
// queued when stimulus is driven and matched as the DUT emits them.
module tb_button_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;
  localparam int          LAT  = DEB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  int         press_seen = 0;
  logic [7:0] exp_cnt = 8'd0;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected-event producers: offset is edge-of-drive + LAT (+LONG for long press)
  task automatic push_press();
    ev_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.kind = 0; e.cyc = edge_n + LAT; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_release();
    ev_t e;
    e.kind = 1; e.cyc = edge_n + LAT; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_long();
    ev_t e;
    e.kind = 2; e.cyc = edge_n + LAT + LONG; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {20'd0, btn_level, press_pulse, release_pulse, long_pulse, press_cnt}, 32'd0);
  endtask

  // Scoreboard: every pulse observed must match the head of the expected queue
  always @(negedge clk) begin : monitor
    int   n;
    int   kind;
    ev_t  e;
    n = int'(press_pulse === 1'b1) + int'(release_pulse === 1'b1) + int'(long_pulse === 1'b1);
    if (n != 0) begin
      kind = (press_pulse === 1'b1) ? 0 : ((release_pulse === 1'b1) ? 1 : 2);
      if (press_pulse === 1'b1) press_seen++;
      check("pulse_overlap", n, 1);
      if (exp_q.size() == 0) begin
        check("spurious_pulse_kind", kind + 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_edge", edge_n, e.cyc);
        check("pulse_cnt", press_cnt, e.cnt);
      end
    end
  end

  initial begin
    int p0;
    rst = 1'b1;
    btn_raw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_outputs");
    end
    rst = 1'b0;
    wait_n(2);

    // Clean press, held 12 cycles, then released
    push_press(); btn_raw = 1'b1; wait_n(12);
    check("clean_level", btn_level, 1);
    check("clean_cnt", press_cnt, 1);
    push_release(); btn_raw = 1'b0; wait_n(10);
    check("clean_release_level", btn_level, 0);

    // Bounces of 3 and 4 high samples are too short to be accepted
    btn_raw = 1'b1; wait_n(3); btn_raw = 1'b0; wait_n(10);
    check("bounce3_level", btn_level, 0);
    btn_raw = 1'b1; wait_n(4); btn_raw = 1'b0; wait_n(10);
    check("bounce4_level", btn_level, 0);
    check("bounce_cnt", press_cnt, exp_cnt);

    // Shortest accepted press: 5 high samples
    push_press(); btn_raw = 1'b1; wait_n(5);
    push_release(); btn_raw = 1'b0; wait_n(12);
    check("min_press_level", btn_level, 0);

    // Long press with a 2-cycle release glitch that must not restart the hold timer
    push_press(); push_long(); btn_raw = 1'b1; wait_n(15);
    btn_raw = 1'b0; wait_n(2); btn_raw = 1'b1; wait_n(3);
    check("glitch_level", btn_level, 1);
    wait_n(20);
    push_release(); btn_raw = 1'b0; wait_n(12);
    check("long_release_level", btn_level, 0);
    check("long_cnt", press_cnt, exp_cnt);

    // Release accepted on the same edge as the long threshold: no long pulse
    push_press(); btn_raw = 1'b1; wait_n(20);
    push_release(); btn_raw = 1'b0; wait_n(12);
    check("tie_level", btn_level, 0);

    // 256 press/release cycles wrap the counter back to its starting value
    p0 = press_seen;
    repeat (256) begin
      push_press(); btn_raw = 1'b1; wait_n(6);
      push_release(); btn_raw = 1'b0; wait_n(8);
    end
    check("wrap_presses", press_seen - p0, 256);
    check("wrap_cnt", press_cnt, exp_cnt);

    // Reset in the middle of a held press, button still held afterwards
    push_press(); btn_raw = 1'b1; wait_n(10);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("midreset_outputs");
    end
    rst = 1'b0;
    exp_cnt = 8'd0;
    push_press();
    @(negedge clk);
    check_all_zero("post_reset_outputs");
    wait_n(12);
    check("post_reset_level", btn_level, 1);
    check("post_reset_cnt", press_cnt, 1);
    push_release(); btn_raw = 1'b0; wait_n(12);
    check("final_level", btn_level, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
